// File: rtl/alu_mdu_seq.sv
// Execute-stage ALU with an iterative multiply/divide unit behind a start/done handshake.
// Base operations finish in one cycle; MUL/MULHU/DIVU/REMU take XLEN iterations.
module alu_mdu_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            opb5,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic [1:0]      ALUOp,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // M-op selector: bit 1 picks the divider, bit 0 picks the upper half (MULHU / REMU)
  localparam logic [1:0] SEL_MUL   = 2'b00;
  localparam logic [1:0] SEL_MULHU = 2'b01;
  localparam logic [1:0] SEL_DIVU  = 2'b10;
  localparam logic [1:0] SEL_REMU  = 2'b11;

  state_t              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [1:0]          msel_q, msel_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, zero_d;

  logic                m_op;
  logic [1:0]          m_sel;
  logic [XLEN-1:0]     base_res;
  logic [SHW-1:0]      sh;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   div_next;

  // Decode and single-cycle datapath
  always_comb begin
    base_res = '0;
    m_op     = 1'b0;
    m_sel    = SEL_MUL;
    sh       = srcb[SHW-1:0];
    case (ALUOp)
      2'b00: base_res = srca + srcb;
      2'b01: base_res = srca - srcb;
      2'b10: begin
        if (opb5 && funct7b0) begin
          case (funct3)
            3'b000: begin m_op = 1'b1; m_sel = SEL_MUL;   end
            3'b011: begin m_op = 1'b1; m_sel = SEL_MULHU; end
            3'b101: begin m_op = 1'b1; m_sel = SEL_DIVU;  end
            3'b111: begin m_op = 1'b1; m_sel = SEL_REMU;  end
            default: base_res = '0;
          endcase
        end else begin
          case (funct3)
            3'b000: base_res = (opb5 && funct7b5) ? (srca - srcb) : (srca + srcb);
            3'b001: base_res = srca << sh;
            3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            3'b011: base_res = {{(XLEN-1){1'b0}}, (srca < srcb)};
            3'b100: base_res = srca ^ srcb;
            3'b101: base_res = funct7b5 ? XLEN'($signed(srca) >>> sh) : (srca >> sh);
            3'b110: base_res = srca | srcb;
            default: base_res = srca & srcb;
          endcase
        end
      end
      default: base_res = '0;
    endcase
  end

  // One radix-2 step of each engine. acc holds {high, low}: for MUL the partial
  // product shifts right while the multiplier drains out of the low half; for DIV
  // the partial remainder sits high and quotient bits shift into the low half.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_shift >= {1'b0, opnd_q}) begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    msel_d   = msel_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (m_op) begin
            state_d = m_sel[1] ? DIV : MUL;
            cnt_d   = SHW'(XLEN-1);
            msel_d  = m_sel;
            // multiplicand for MUL, divisor for DIV; the other operand seeds acc
            opnd_d  = m_sel[1] ? srcb : srca;
            acc_d   = m_sel[1] ? {{XLEN{1'b0}}, srca} : {{XLEN{1'b0}}, srcb};
          end else begin
            state_d  = DONE;
            result_d = base_res;
            zero_d   = (base_res == '0);
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = msel_q[0] ? mul_next[2*XLEN-1:XLEN] : mul_next[XLEN-1:0];
          zero_d   = (result_d == '0);
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = msel_q[0] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
          zero_d   = (result_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      msel_q   <= SEL_MUL;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      msel_q   <= msel_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Operand and accumulator storage is only meaningful while iterating
  always_ff @(posedge clk) begin
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
  end

  assign busy   = (state_q == MUL) || (state_q == DIV);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign zero   = zero_q;

endmodule
